// File: rtl/fadd_pkg.sv
// fadd_pkg: shared types and helpers for the pipelined adder.
// Mode encoding, chunk-width helper and signed-overflow rule.
package fadd_pkg;

  typedef enum logic {
    FADD_ADD = 1'b0,
    FADD_SUB = 1'b1
  } fadd_mode_e;

  function automatic int fadd_cw(int w, int s);
    return (s < 1) ? w : w / s;
  endfunction

  function automatic logic fadd_ovf(
    logic a_msb,
    logic b_msb,
    logic r_msb
  );
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/fadd_if.sv
// fadd_if: operand and result bundle of the pipelined adder.
// master drives operations, slave returns results.
interface fadd_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] r;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub,
    input  out_valid, r, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub,
    output out_valid, r, cout, ovf
  );
endinterface

// File: rtl/fadd_chunk.sv
// fadd_chunk: combinational CW-bit slice of the carry chain.
// One instance per pipeline stage.
module fadd_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);
  assign {co, s} = {1'b0, a} + {1'b0, b}
                 + {{CW{1'b0}}, ci};
endmodule

// File: rtl/fadd_pipe.sv
// fadd_pipe: pipelined add/sub, carry chain cut into STAGES chunks.
// Operands skew forward, finished chunks deskew alongside.
module fadd_pipe
  import fadd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic   clk,
  input logic   rst_n,
  input logic   en,
  fadd_if.slave io
);
  localparam int CW = fadd_cw(WIDTH, STAGES);
  localparam int SG = (STAGES < 1) ? 1 : STAGES;

  if ((STAGES < 1) || ((WIDTH % SG) != 0)) begin : g_bad
    $error("fadd_pipe: WIDTH must be a multiple of STAGES >= 1");
  end

  fadd_mode_e       mode;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Subtract is a + ~b + ~cin, so cout reads as "no borrow".
  assign mode = fadd_mode_e'(io.sub);
  assign b_in = (mode == FADD_SUB) ? ~io.b : io.b;
  assign c_in = (mode == FADD_SUB) ? ~io.cin : io.cin;

  logic             v_q  [STAGES];
  logic             c_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             ovf_q;

  logic             v_d  [STAGES];
  logic             c_d  [STAGES];
  logic             ci   [STAGES];
  logic [WIDTH-1:0] a_d  [STAGES];
  logic [WIDTH-1:0] b_d  [STAGES];
  logic [WIDTH-1:0] s_d  [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam logic [WIDTH-1:0] MASK =
      WIDTH'({CW{1'b1}}) << (k * CW);
    logic [CW-1:0]    sum;
    logic [WIDTH-1:0] s_src;

    if (k == 0) begin : g_head
      assign v_d[k] = io.in_valid;
      assign a_d[k] = io.a;
      assign b_d[k] = b_in;
      assign ci[k]  = c_in;
      assign s_src  = '0;
    end else begin : g_body
      assign v_d[k] = v_q[k-1];
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign ci[k]  = c_q[k-1];
      assign s_src  = s_q[k-1];
    end

    fadd_chunk #(.CW(CW)) u_chunk (
      .a  (a_d[k][k*CW +: CW]),
      .b  (b_d[k][k*CW +: CW]),
      .ci (ci[k]),
      .s  (sum),
      .co (c_d[k])
    );

    assign s_d[k] = (s_src & ~MASK)
                  | ((WIDTH'(sum) << (k * CW)) & MASK);
  end

  // The last slot doubles as the output register: it only
  // loads on a valid beat so r/cout/ovf hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        if (k < STAGES - 1) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end else if (v_d[k]) begin
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
          ovf_q  <= fadd_ovf(a_d[k][WIDTH-1],
                             b_d[k][WIDTH-1],
                             s_d[k][WIDTH-1]);
        end
      end
    end
  end

  assign io.out_valid = v_q[STAGES-1];
  assign io.r         = s_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: four parameterisations share one stimulus stream,
// each checked against a plain-arithmetic model with latency tags.
module tb_fadd_pipe;
  logic        clk = 1'b0;
  logic        rst_n, en, iv, cin, sub;
  logic [15:0] a, b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  fadd_if #(.WIDTH(16)) if16 ();
  fadd_if #(.WIDTH(8))  if8  ();
  fadd_if #(.WIDTH(4))  if41 ();
  fadd_if #(.WIDTH(4))  if44 ();

  assign if16.in_valid = iv;
  assign if16.a        = a;
  assign if16.b        = b;
  assign if16.cin      = cin;
  assign if16.sub      = sub;
  assign if8.in_valid  = iv;
  assign if8.a         = a[7:0];
  assign if8.b         = b[7:0];
  assign if8.cin       = cin;
  assign if8.sub       = sub;
  assign if41.in_valid = iv;
  assign if41.a        = a[3:0];
  assign if41.b        = b[3:0];
  assign if41.cin      = cin;
  assign if41.sub      = sub;
  assign if44.in_valid = iv;
  assign if44.a        = a[3:0];
  assign if44.b        = b[3:0];
  assign if44.cin      = cin;
  assign if44.sub      = sub;

  fadd_pipe #(.WIDTH(16), .STAGES(4)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .io(if16));
  fadd_pipe #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .io(if8));
  fadd_pipe #(.WIDTH(4), .STAGES(1)) u41 (
    .clk(clk), .rst_n(rst_n), .en(en), .io(if41));
  fadd_pipe #(.WIDTH(4), .STAGES(4)) u44 (
    .clk(clk), .rst_n(rst_n), .en(en), .io(if44));

  logic        ov [4];
  logic        co [4];
  logic        of [4];
  logic [15:0] rr [4];

  assign ov[0] = if16.out_valid;
  assign co[0] = if16.cout;
  assign of[0] = if16.ovf;
  assign rr[0] = if16.r;
  assign ov[1] = if8.out_valid;
  assign co[1] = if8.cout;
  assign of[1] = if8.ovf;
  assign rr[1] = {8'd0, if8.r};
  assign ov[2] = if41.out_valid;
  assign co[2] = if41.cout;
  assign of[2] = if41.ovf;
  assign rr[2] = {12'd0, if41.r};
  assign ov[3] = if44.out_valid;
  assign co[3] = if44.cout;
  assign of[3] = if44.ovf;
  assign rr[3] = {12'd0, if44.r};

  function automatic int wid(int d);
    return (d == 0) ? 16 : (d == 1) ? 8 : 4;
  endfunction

  function automatic int stg(int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : (d == 2) ? 1 : 4;
  endfunction

  // Reference: unsigned result/carry and signed overflow from
  // integer arithmetic, returned as {ovf, cout, r}.
  function automatic logic [17:0] ref_op(
    int w, logic [15:0] x, logic [15:0] y, logic c, logic s);
    longint m, h, ux, uy, sx, sy, u, v;
    logic   cy, vo;
    m  = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = (ux >= h) ? ux - 2 * h : ux;
    sy = (uy >= h) ? uy - 2 * h : uy;
    if (s) begin
      u  = ux - uy - longint'(c);
      v  = sx - sy - longint'(c);
      cy = (u >= 0);
    end else begin
      u  = ux + uy + longint'(c);
      v  = sx + sy + longint'(c);
      cy = (u > m);
    end
    vo = (v >= h) || (v < -h);
    return {vo, cy, 16'(u & m)};
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [18:0] got,
                     input logic [18:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s dut%0d t=%0t got=%h want=%h",
                 nm, d, $time, got, want);
    end
  endtask

  typedef struct {
    logic [17:0] exp;
    int          due;
  } item_t;

  item_t       q [4][$];
  int          e = 0;
  logic [18:0] last [4];

  // Scoreboard: ops are tagged with the enabled edge on which they
  // must appear; stalls, bubbles and reset are checked every edge.
  always @(posedge clk) begin : mon
    logic        r_s, en_s, iv_s, c_s, s_s;
    logic [15:0] a_s, b_s;
    logic [18:0] got;
    r_s  = rst_n;
    en_s = en;
    iv_s = iv;
    a_s  = a;
    b_s  = b;
    c_s  = cin;
    s_s  = sub;
    if (r_s && en_s) begin
      e++;
      if (iv_s)
        for (int d = 0; d < 4; d++)
          q[d].push_back('{ref_op(wid(d), a_s, b_s, c_s, s_s),
                           e + stg(d) - 1});
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      got = {ov[d], of[d], co[d], rr[d]};
      if (!r_s) begin
        q[d].delete();
        last[d] = '0;
        chk("reset", d, got, 19'd0);
      end else if (!en_s) begin
        chk("stall_hold", d, got, last[d]);
      end else if (q[d].size() != 0 && q[d][0].due == e) begin
        last[d] = {1'b1, q[d][0].exp};
        chk("beat", d, got, last[d]);
        void'(q[d].pop_front());
      end else begin
        last[d][18] = 1'b0;
        chk("idle_hold", d, got, last[d]);
      end
    end
  end

  task automatic drive(input logic e_i, input logic v_i,
                       input logic [15:0] a_i,
                       input logic [15:0] b_i,
                       input logic c_i, input logic s_i);
    @(negedge clk);
    en  = e_i;
    iv  = v_i;
    a   = a_i;
    b   = b_i;
    cin = c_i;
    sub = s_i;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] r;
    logic        co, ov;
  } vec_t;

  vec_t tv [10];

  initial begin : wd
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          s1, s2, k, nv;
    logic [7:0]  pat;
    logic [18:0] got;

    tv[0] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    tv[1] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    tv[2] = '{16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0};
    tv[3] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
    tv[4] = '{16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0};
    tv[5] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    tv[6] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0};
    tv[7] = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
    tv[8] = '{16'h0000, 16'h0001, 1, 1, 16'hFFFE, 0, 0};
    tv[9] = '{16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0};

    rst_n = 1'b0;
    en    = 1'b0;
    iv    = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      drive(1, 1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      for (int j = 1; j <= 4; j++) begin
        @(posedge clk);
        #1;
        if (j == 1) iv = 1'b0;
        if (j < 4) chk("early_valid", 0, 19'(ov[0]), 19'd0);
        else chk("vector", 0, {ov[0], of[0], co[0], rr[0]},
                 {1'b1, tv[i].ov, tv[i].co, tv[i].r});
      end
    end

    for (int i = 0; i < 3; i++)
      drive(1, 1, 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    iv    = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      got = {ov[d], of[d], co[d], rr[d]};
      chk("async_reset", d, got, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) drive(1, 0, 0, 0, 0, 0);

    pat = 8'b1100_1011;
    s1  = $urandom_range(1, 9);
    s2  = s1 + $urandom_range(1, 3);
    k   = 0;
    nv  = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == s1 || c == s2) begin
        drive(0, 1, 16'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom));
      end else begin
        drive(1, (k < 8) ? pat[k[2:0]] : 1'b0,
              16'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom));
        k++;
      end
      @(posedge clk);
      #1;
      if (en && ov[0]) nv++;
    end
    chk("beat_count", 0, 19'(nv), 19'd5);

    for (int i = 0; i < 512; i++)
      drive(1, 1, {12'($urandom), i[3:0]},
            {12'($urandom), i[7:4]}, i[8], 1'b0);

    for (int i = 0; i < 65536; i++)
      drive(1, 1, {8'($urandom), i[7:0]},
            {8'($urandom), i[15:8]},
            1'($urandom), 1'($urandom));

    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
            16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));

    repeat (10) drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    for (int d = 0; d < 4; d++)
      chk("drained", d, 19'(q[d].size()), 19'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
